// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the traffic light conflict monitor slice.
//   - Lamp code constants (one-hot red/yellow/green, plus all-off)
//   - mode_t       : monitor state, also driven out on o_mode
//   - fault_code_t : latched fault cause, driven out on o_fault_code
//   - helpers that classify a single 3-bit lamp code
// ---------------------------------------------------------------------------
package tlc_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [1:0] {
        MODE_STARTUP = 2'b00,
        MODE_NORMAL  = 2'b01,
        MODE_FAULT   = 2'b10,
        MODE_RECOVER = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_CONFLICT = 2'b01,
        FC_INVALID  = 2'b10,
        FC_WDOG     = 2'b11
    } fault_code_t;

    // A code is legal only if it is exactly one of the three lit aspects.
    function automatic logic isValidCode(input logic [2:0] code);
        return (code == LAMP_RED) || (code == LAMP_YEL) || (code == LAMP_GRN);
    endfunction

    // Green or yellow both give right of way, so both count as "open".
    function automatic logic isNonRed(input logic [2:0] code);
        return (code == LAMP_YEL) || (code == LAMP_GRN);
    endfunction

endpackage

// File: rtl/tlc_conflict_check.sv
// ---------------------------------------------------------------------------
// tlc_conflict_check
// Purely combinational classifier for one sample of the four lamp codes.
// Ports:
//   i_light_M1/M2/MT/S [2:0] : controller lamp codes
//   o_invalid               : some code is not exactly 100, 010 or 001
//   o_conflict              : two incompatible approaches are open together
//   o_unsafe                : o_invalid | o_conflict
// ---------------------------------------------------------------------------
module tlc_conflict_check
    import tlc_pkg::*;
(
    input  logic [2:0] i_light_M1,
    input  logic [2:0] i_light_M2,
    input  logic [2:0] i_light_MT,
    input  logic [2:0] i_light_S,
    output logic       o_invalid,
    output logic       o_conflict,
    output logic       o_unsafe
);

    logic w_openM1;
    logic w_openM2;
    logic w_openMT;
    logic w_openS;

    assign w_openM1 = isNonRed(i_light_M1);
    assign w_openM2 = isNonRed(i_light_M2);
    assign w_openMT = isNonRed(i_light_MT);
    assign w_openS  = isNonRed(i_light_S);

    assign o_invalid = !isValidCode(i_light_M1) || !isValidCode(i_light_M2) ||
                       !isValidCode(i_light_MT) || !isValidCode(i_light_S);

    // The side road crosses every main movement; the main turn crosses only
    // the opposing main through (M2). M1+M2 and M1+MT are compatible.
    assign o_conflict = (w_openS && (w_openM1 || w_openM2 || w_openMT)) ||
                        (w_openMT && w_openM2);

    assign o_unsafe = o_invalid || o_conflict;

endmodule

// File: rtl/tlc_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tlc_conflict_monitor
// Safety stage between the traffic light controller and the lamp drivers.
// Safe samples pass through with one cycle of latency; unsafe samples are
// replaced by all-red, and a run of CONFLICT_CYCLES unsafe samples latches an
// all-red flashing failsafe that is left only through i_fault_clr.
// Optional feature macro: TLC_WATCHDOG_EN (frozen-input watchdog, code 11).
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_light_M1/M2/MT/S [2:0]     : controller lamp codes
//   i_fault_clr                  : leave failsafe (only honoured in FAULT)
//   o_lamp_M1/M2/MT/S [2:0]      : registered lamp drive
//   o_fault                      : high while in FAULT
//   o_fault_code [1:0]           : 00 none, 01 conflict, 10 invalid, 11 wdog
//   o_mode [1:0]                 : 00 STARTUP, 01 NORMAL, 10 FAULT, 11 RECOVER
// ---------------------------------------------------------------------------
module tlc_conflict_monitor
    import tlc_pkg::*;
#(
    parameter int ALLRED_CYCLES   = 4,
    parameter int CONFLICT_CYCLES = 2,
    parameter int FLASH_HALF      = 4,
    parameter int WDOG_CYCLES     = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_light_M1,
    input  logic [2:0] i_light_M2,
    input  logic [2:0] i_light_MT,
    input  logic [2:0] i_light_S,
    input  logic       i_fault_clr,
    output logic [2:0] o_lamp_M1,
    output logic [2:0] o_lamp_M2,
    output logic [2:0] o_lamp_MT,
    output logic [2:0] o_lamp_S,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic [1:0] o_mode
);

    localparam int TIMER_W  = $clog2(ALLRED_CYCLES) + 1;
    localparam int UNSAFE_W = $clog2(CONFLICT_CYCLES) + 1;
    localparam int FLASH_W  = $clog2(FLASH_HALF) + 1;

    localparam logic [TIMER_W-1:0]  TIMER_LAST   = TIMER_W'(ALLRED_CYCLES - 1);
    localparam logic [UNSAFE_W-1:0] UNSAFE_LIMIT = UNSAFE_W'(CONFLICT_CYCLES);
    localparam logic [FLASH_W-1:0]  FLASH_LAST   = FLASH_W'(2 * FLASH_HALF - 1);
    localparam logic [FLASH_W-1:0]  FLASH_MID    = FLASH_W'(FLASH_HALF);
    localparam logic [11:0] ALL_RED = {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};
    localparam logic [11:0] ALL_OFF = {LAMP_OFF, LAMP_OFF, LAMP_OFF, LAMP_OFF};

    mode_t               r_mode,      w_modeNext;
    fault_code_t         r_faultCode, w_codeNext;
    logic                r_fault,     w_faultNext;
    logic [11:0]         r_lamps,     w_lampsNext;
    logic [TIMER_W-1:0]  r_timer,     w_timerNext;
    logic [UNSAFE_W-1:0] r_unsafeCnt, w_unsafeNext;
    logic [FLASH_W-1:0]  r_flashCnt,  w_flashNext;

    logic [11:0] w_inVec;
    logic        w_invalid;
    logic        w_conflict;
    logic        w_unsafe;
    logic        w_wdogFire;

    assign w_inVec = {i_light_M1, i_light_M2, i_light_MT, i_light_S};

    tlc_conflict_check u_check (
        .i_light_M1 (i_light_M1),
        .i_light_M2 (i_light_M2),
        .i_light_MT (i_light_MT),
        .i_light_S  (i_light_S),
        .o_invalid  (w_invalid),
        .o_conflict (w_conflict),
        .o_unsafe   (w_unsafe)
    );

`ifdef TLC_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

    logic [11:0]       r_prevVec;
    logic [WDOG_W-1:0] r_wdogCnt;
    logic [WDOG_W-1:0] w_wdogNext;

    // Counts consecutive identical samples while in NORMAL only, so the count
    // is always zero on entry to NORMAL.
    always_comb begin
        w_wdogNext = '0;
        if (r_mode == MODE_NORMAL && w_inVec == r_prevVec) begin
            w_wdogNext = (r_wdogCnt == '1) ? r_wdogCnt : r_wdogCnt + 1'b1;
        end
    end

    assign w_wdogFire = (r_mode == MODE_NORMAL) && (w_wdogNext == WDOG_LIMIT);

    // The previous sample is tracked in every state so the first NORMAL
    // comparison is against a real sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prevVec <= '0;
            r_wdogCnt <= '0;
        end else begin
            r_prevVec <= w_inVec;
            r_wdogCnt <= w_wdogNext;
        end
    end
`else
    // WDOG_CYCLES stays in the parameter list so both builds share one
    // interface; the expression is constant zero.
    assign w_wdogFire = 1'b0 & (WDOG_CYCLES != 0);
`endif

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so nothing reaches the lamps combinationally.
    always_comb begin
        w_modeNext   = r_mode;
        w_codeNext   = r_faultCode;
        w_faultNext  = r_fault;
        w_lampsNext  = ALL_RED;
        w_timerNext  = '0;
        w_unsafeNext = '0;
        w_flashNext  = '0;

        case (r_mode)
            MODE_STARTUP, MODE_RECOVER: begin
                if (r_timer == TIMER_LAST) begin
                    w_modeNext = MODE_NORMAL;
                end else begin
                    w_timerNext = r_timer + 1'b1;
                end
            end

            MODE_NORMAL: begin
                if (w_unsafe) begin
                    w_unsafeNext = (r_unsafeCnt == '1) ? r_unsafeCnt
                                                       : r_unsafeCnt + 1'b1;
                end else begin
                    w_lampsNext = w_inVec;
                end
                // The sample's own cause outranks the watchdog when they
                // coincide; invalid outranks conflict.
                if (w_unsafeNext == UNSAFE_LIMIT || w_wdogFire) begin
                    w_modeNext   = MODE_FAULT;
                    w_faultNext  = 1'b1;
                    w_lampsNext  = ALL_RED;
                    w_unsafeNext = '0;
                    if (w_invalid) begin
                        w_codeNext = FC_INVALID;
                    end else if (w_conflict) begin
                        w_codeNext = FC_CONFLICT;
                    end else begin
                        w_codeNext = FC_WDOG;
                    end
                end
            end

            MODE_FAULT: begin
                // Flash phase counter restarts each period: first half red,
                // second half dark.
                w_flashNext = (r_flashCnt == FLASH_LAST) ? '0 : r_flashCnt + 1'b1;
                w_lampsNext = (w_flashNext < FLASH_MID) ? ALL_RED : ALL_OFF;
                if (i_fault_clr && !w_unsafe) begin
                    w_modeNext  = MODE_RECOVER;
                    w_faultNext = 1'b0;
                    w_codeNext  = FC_NONE;
                    w_lampsNext = ALL_RED;
                    w_flashNext = '0;
                end
            end

            default: begin
                w_modeNext = MODE_STARTUP;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode      <= MODE_STARTUP;
            r_faultCode <= FC_NONE;
            r_fault     <= 1'b0;
            r_lamps     <= ALL_RED;
            r_timer     <= '0;
            r_unsafeCnt <= '0;
            r_flashCnt  <= '0;
        end else begin
            r_mode      <= w_modeNext;
            r_faultCode <= w_codeNext;
            r_fault     <= w_faultNext;
            r_lamps     <= w_lampsNext;
            r_timer     <= w_timerNext;
            r_unsafeCnt <= w_unsafeNext;
            r_flashCnt  <= w_flashNext;
        end
    end

    assign o_lamp_M1    = r_lamps[11:9];
    assign o_lamp_M2    = r_lamps[8:6];
    assign o_lamp_MT    = r_lamps[5:3];
    assign o_lamp_S     = r_lamps[2:0];
    assign o_fault      = r_fault;
    assign o_fault_code = r_faultCode;
    assign o_mode       = r_mode;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_conflict_monitor
// Directed bench for tlc_conflict_monitor with hand-computed expectations.
// Lamp vectors are written {M1, M2, MT, S}. Watchdog section depends on
// TLC_WATCHDOG_EN.
// ---------------------------------------------------------------------------
module tb_tlc_conflict_monitor;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;
    localparam logic [11:0] ALLRED = {RED, RED, RED, RED};
    localparam logic [11:0] ALLOFF = {OFF, OFF, OFF, OFF};

    logic       clk;
    logic       rst;
    logic [2:0] lightM1, lightM2, lightMT, lightS;
    logic       faultClr;
    logic [2:0] lampM1, lampM2, lampMT, lampS;
    logic       fault;
    logic [1:0] faultCode;
    logic [1:0] mode;

    int checkCount = 0;
    int errCount   = 0;

    tlc_conflict_monitor dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_light_M1   (lightM1),
        .i_light_M2   (lightM2),
        .i_light_MT   (lightMT),
        .i_light_S    (lightS),
        .i_fault_clr  (faultClr),
        .o_lamp_M1    (lampM1),
        .o_lamp_M2    (lampM2),
        .o_lamp_MT    (lampMT),
        .o_lamp_S     (lampS),
        .o_fault      (fault),
        .o_fault_code (faultCode),
        .o_mode       (mode)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the controller inputs and the clear request.
    task automatic applyStimulus(input logic [2:0] m1, input logic [2:0] m2,
                                 input logic [2:0] mt, input logic [2:0] s,
                                 input logic clr);
        lightM1  = m1;
        lightM2  = m2;
        lightMT  = mt;
        lightS   = s;
        faultClr = clr;
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values.
    task automatic checkOutput(input string tag, input logic [11:0] expLamps,
                               input logic [1:0] expMode, input logic expFault,
                               input logic [1:0] expCode);
        logic [11:0] obsLamps;
        obsLamps = {lampM1, lampM2, lampMT, lampS};
        checkCount++;
        assert (obsLamps === expLamps) else begin
            errCount++;
            $error("[TB] FAIL %s lamps: observed %b expected %b", tag, obsLamps, expLamps);
        end
        checkCount++;
        assert (mode === expMode) else begin
            errCount++;
            $error("[TB] FAIL %s mode: observed %b expected %b", tag, mode, expMode);
        end
        checkCount++;
        assert (fault === expFault) else begin
            errCount++;
            $error("[TB] FAIL %s fault: observed %b expected %b", tag, fault, expFault);
        end
        checkCount++;
        assert (faultCode === expCode) else begin
            errCount++;
            $error("[TB] FAIL %s fault_code: observed %b expected %b", tag, faultCode, expCode);
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        applyStimulus(RED, RED, RED, RED, 1'b0);
        step();
        step();
        checkOutput("reset", ALLRED, 2'b00, 1'b0, 2'b00);

        // Startup hold, then pass-through of M1+M2 green
        rst = 1'b0;
        applyStimulus(GRN, GRN, RED, RED, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput("startup_hold", ALLRED, 2'b00, 1'b0, 2'b00);
        end
        step();
        checkOutput("startup_to_normal", ALLRED, 2'b01, 1'b0, 2'b00);
        step();
        checkOutput("pass_m1_m2", {GRN, GRN, RED, RED}, 2'b01, 1'b0, 2'b00);

        // Single-cycle S/M1 conflict is filtered
        applyStimulus(GRN, RED, RED, GRN, 1'b0);
        step();
        checkOutput("glitch_red", ALLRED, 2'b01, 1'b0, 2'b00);
        applyStimulus(GRN, RED, GRN, RED, 1'b0);
        step();
        checkOutput("glitch_resume_m1_mt", {GRN, RED, GRN, RED}, 2'b01, 1'b0, 2'b00);

        // Confirmed MT/M2 conflict
        applyStimulus(RED, YEL, GRN, RED, 1'b0);
        step();
        checkOutput("conflict_first", ALLRED, 2'b01, 1'b0, 2'b00);
        step();
        checkOutput("conflict_fault", ALLRED, 2'b10, 1'b1, 2'b01);
        for (int i = 1; i <= 8; i++) begin
            step();
            checkOutput("flash", (i <= 3 || i == 8) ? ALLRED : ALLOFF, 2'b10, 1'b1, 2'b01);
        end

        // Clear refused while the conflict persists
        applyStimulus(RED, YEL, GRN, RED, 1'b1);
        step();
        checkOutput("clear_refused", ALLRED, 2'b10, 1'b1, 2'b01);

        // Clear accepted with a safe vector, then recovery hold
        applyStimulus(GRN, GRN, RED, RED, 1'b1);
        step();
        checkOutput("clear_accept", ALLRED, 2'b11, 1'b0, 2'b00);
        applyStimulus(GRN, GRN, RED, RED, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput("recover_hold", ALLRED, 2'b11, 1'b0, 2'b00);
        end
        step();
        checkOutput("recover_to_normal", ALLRED, 2'b01, 1'b0, 2'b00);
        step();
        checkOutput("recover_pass", {GRN, GRN, RED, RED}, 2'b01, 1'b0, 2'b00);

        // Invalid MT code with S/M1 conflict: invalid wins
        applyStimulus(GRN, RED, 3'b011, GRN, 1'b0);
        step();
        checkOutput("priority_first", ALLRED, 2'b01, 1'b0, 2'b00);
        step();
        checkOutput("priority_fault", ALLRED, 2'b10, 1'b1, 2'b10);

        // Reset in the middle of the flash
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("reset_mid_flash", ALLRED, 2'b00, 1'b0, 2'b00);

        // Restart and freeze a safe vector
        rst = 1'b0;
        applyStimulus(RED, RED, RED, GRN, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
        end
        checkOutput("restart_normal", ALLRED, 2'b01, 1'b0, 2'b00);
`ifdef TLC_WATCHDOG_EN
        for (int i = 1; i <= 15; i++) begin
            step();
            checkOutput("wdog_below_limit", {RED, RED, RED, GRN}, 2'b01, 1'b0, 2'b00);
        end
        step();
        checkOutput("wdog_fault", ALLRED, 2'b10, 1'b1, 2'b11);
`else
        for (int i = 1; i <= 100; i++) begin
            step();
            checkOutput("frozen_pass", {RED, RED, RED, GRN}, 2'b01, 1'b0, 2'b00);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
